// File: rtl/viterbi_frame_sequencer.sv
// Frame sequencer for the encoder -> channel -> Viterbi decoder chain: serialises a message
// LSB-first with a zero tail, captures the decoded bits at fixed latency and counts bit errors.
module viterbi_frame_sequencer #(
    parameter int FRAME_LEN = 32,
    parameter int TAIL_LEN  = 2,
    parameter int DEC_LAT   = 16,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_valid_i,
    input  logic [FRAME_LEN-1:0]           frame_data_i,
    output logic                           frame_ready_o,
    input  logic                           abort_i,
    output logic                           enc_enable_o,
    output logic                           enc_bit_o,
    input  logic                           dec_bit_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [FRAME_LEN-1:0]           dec_frame_o,
    output logic [$clog2(FRAME_LEN+1)-1:0] frame_err_o,
    output logic [CNT_W-1:0]               total_err_o,
    output logic [CNT_W-1:0]               frame_cnt_o
);
    localparam int TW = $clog2(DEC_LAT + FRAME_LEN + 1);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int FW = $clog2(FRAME_LEN + 1);
    localparam int SW = ((CNT_W > FW) ? CNT_W : FW) + 1;
    localparam logic [TW-1:0]    T_LAST = TW'(DEC_LAT + FRAME_LEN - 1);
    localparam logic [TW-1:0]    T_DEC0 = TW'(DEC_LAT);
    localparam logic [TW-1:0]    T_FL   = TW'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CMAX   = '1;

    // The tail must be fully shifted in before the decoder window closes.
    if (DEC_LAT < TAIL_LEN) begin : g_bad_lat
        $error("DEC_LAT must be >= TAIL_LEN");
    end

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t               r_state;
    logic [TW-1:0]        r_t;
    logic [FRAME_LEN-1:0] r_frame;
    logic [FRAME_LEN-1:0] r_dec;
    logic [FW-1:0]        r_ferr;
    logic [FRAME_LEN-1:0] r_dec_out;
    logic [FW-1:0]        r_ferr_out;
    logic [CNT_W-1:0]     r_total;
    logic [CNT_W-1:0]     r_cnt;

    logic [IW-1:0]    w_didx;
    logic             w_cap;
    logic             w_in_msg;
    logic             w_commit;
    logic [SW-1:0]    w_tot_sum;
    logic [CNT_W-1:0] w_tot_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_didx    = IW'(r_t - T_DEC0);
    assign w_cap     = (r_t >= T_DEC0);
    assign w_in_msg  = (r_t < T_FL);
    assign w_tot_sum = SW'(r_total) + SW'(r_ferr);
    assign w_tot_nxt = (w_tot_sum > SW'(CMAX)) ? CMAX : w_tot_sum[CNT_W-1:0];
    assign w_cnt_nxt = (r_cnt == CMAX) ? CMAX : r_cnt + CNT_W'(1);

    // Results are presented during REPORT but only committed on its exit, so an abort
    // arriving in REPORT can still suppress the pulse and leave the counters untouched.
    assign w_commit      = (r_state == REPORT) && !abort_i;
    assign frame_ready_o = (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);
    assign enc_enable_o  = (r_state == RUN);
    assign enc_bit_o     = (r_state == RUN) && w_in_msg && r_frame[r_t[IW-1:0]];
    assign done_o        = w_commit;
    assign dec_frame_o   = w_commit ? r_dec     : r_dec_out;
    assign frame_err_o   = w_commit ? r_ferr    : r_ferr_out;
    assign total_err_o   = w_commit ? w_tot_nxt : r_total;
    assign frame_cnt_o   = w_commit ? w_cnt_nxt : r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_t        <= '0;
            r_frame    <= '0;
            r_dec      <= '0;
            r_ferr     <= '0;
            r_dec_out  <= '0;
            r_ferr_out <= '0;
            r_total    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_valid_i) begin
                        r_frame <= frame_data_i;
                        r_t     <= '0;
                        r_ferr  <= '0;
                        r_dec   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                    end else begin
                        if (w_cap) begin
                            r_dec[w_didx] <= dec_bit_i;
                            if (dec_bit_i != r_frame[w_didx]) r_ferr <= r_ferr + FW'(1);
                        end
                        if (r_t == T_LAST) r_state <= REPORT;
                        else               r_t     <= r_t + TW'(1);
                    end
                end
                REPORT: begin
                    r_state <= IDLE;
                    if (!abort_i) begin
                        r_dec_out  <= r_dec;
                        r_ferr_out <= r_ferr;
                        r_total    <= w_tot_nxt;
                        r_cnt      <= w_cnt_nxt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_frame_sequencer.sv
// Bench for viterbi_frame_sequencer: loopback channel with bit-flip injection, frame-level
// reference model, plus a narrow-counter instance for saturation.
module tb_viterbi_frame_sequencer;
    localparam int FL = 8;
    localparam int DL = 4;
    localparam int CW = 16;
    localparam int RL = DL + FL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          valid, abort, ready, en, enc_bit, dec_bit, busy, done;
    logic [FL-1:0] data, dec_frame;
    logic [3:0]    ferr;
    logic [CW-1:0] total, cnt;

    logic       s_valid, s_ready, s_en, s_bit, s_dec, s_busy, s_done;
    logic [7:0] s_data, s_dframe;
    logic [3:0] s_ferr;
    logic [1:0] s_total, s_cnt;

    viterbi_frame_sequencer #(.FRAME_LEN(FL), .TAIL_LEN(2), .DEC_LAT(DL), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .frame_valid_i(valid), .frame_data_i(data), .frame_ready_o(ready),
        .abort_i(abort), .enc_enable_o(en), .enc_bit_o(enc_bit), .dec_bit_i(dec_bit),
        .busy_o(busy), .done_o(done), .dec_frame_o(dec_frame), .frame_err_o(ferr),
        .total_err_o(total), .frame_cnt_o(cnt));

    viterbi_frame_sequencer #(.FRAME_LEN(FL), .TAIL_LEN(2), .DEC_LAT(DL), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .frame_valid_i(s_valid), .frame_data_i(s_data), .frame_ready_o(s_ready),
        .abort_i(1'b0), .enc_enable_o(s_en), .enc_bit_o(s_bit), .dec_bit_i(s_dec),
        .busy_o(s_busy), .done_o(s_done), .dec_frame_o(s_dframe), .frame_err_o(s_ferr),
        .total_err_o(s_total), .frame_cnt_o(s_cnt));

    // Channel: DL-clock delay line; flip[j] inverts decoded message bit j.
    logic [3:0] sr = '0;
    logic [3:0] s_sr = '0;
    int         k = 0;
    logic [FL-1:0] flip = '0;
    always @(posedge clk) begin
        sr   <= {sr[2:0], enc_bit};
        s_sr <= {s_sr[2:0], s_bit};
        k    <= en ? k + 1 : 0;
    end
    assign dec_bit = sr[3] ^ ((k >= DL && k < RL) ? flip[k-DL] : 1'b0);
    assign s_dec   = ~s_sr[3];

    int n_chk = 0, n_err = 0;
    int m_total = 0, m_cnt = 0, m_ferr = 0;
    logic [FL-1:0] m_dec = '0;
    int s_mtotal = 0, s_mcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk_results(input string tag);
        chk({tag, "_dec"}, 32'(dec_frame), 32'(m_dec));
        chk({tag, "_ferr"}, 32'(ferr), 32'(m_ferr));
        chk({tag, "_total"}, 32'(total), 32'(m_total));
        chk({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
    endtask

    // ab_at: RUN cycle t to abort in, RL to abort in REPORT, negative for none.
    task automatic run_frame(input logic [FL-1:0] d, input logic [FL-1:0] m, input bit keep,
                             input int ab_at, input bit b2b);
        int w;
        w = 0;
        flip = m;
        while (!ready && w < 100) begin @(posedge clk); #1; w++; end
        if (b2b) chk("b2b_idle_gap", 32'(w), 32'd0);
        else     chk("ready_wait", 32'(w < 100), 32'd1);
        valid = 1'b1; data = d;
        @(posedge clk); #1;
        if (!keep) valid = 1'b0;
        for (int t = 0; t < RL; t++) begin
            chk("run_en", 32'(en), 32'd1);
            chk("run_bit", 32'(enc_bit), (t < FL) ? 32'(d[t]) : 32'd0);
            chk("run_busy_ready", 32'({busy, ready}), 32'b10);
            if (t == ab_at) abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            if (t == ab_at) begin
                chk("abort_en", 32'(en), 32'd0);
                chk("abort_ready", 32'(ready), 32'd1);
                chk("abort_done", 32'(done), 32'd0);
                chk_results("abort");
                return;
            end
        end
        if (ab_at == RL) begin
            abort = 1'b1; #1;
            chk("rep_abort_done", 32'(done), 32'd0);
            chk_results("rep_abort");
            @(posedge clk); #1;
            abort = 1'b0;
            chk("rep_abort_ready", 32'(ready), 32'd1);
            chk_results("rep_abort_after");
            return;
        end
        m_dec   = d ^ m;
        m_ferr  = $countones(m);
        m_total = sat(m_total + m_ferr, (1 << CW) - 1);
        m_cnt   = sat(m_cnt + 1, (1 << CW) - 1);
        chk("rep_done", 32'(done), 32'd1);
        chk("rep_en", 32'(en), 32'd0);
        chk("rep_ready", 32'(ready), 32'd0);
        chk_results("rep");
        @(posedge clk); #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_ready", 32'(ready), 32'd1);
        chk_results("hold");
    endtask

    task automatic run_sat();
        int w;
        w = 0;
        while (!s_ready && w < 100) begin @(posedge clk); #1; w++; end
        s_valid = 1'b1; s_data = 8'($urandom);
        @(posedge clk); #1;
        s_valid = 1'b0;
        w = 0;
        while (!s_done && w < 40) begin @(posedge clk); #1; w++; end
        chk("sat_done_seen", 32'(s_done), 32'd1);
        s_mtotal = sat(s_mtotal + FL, 3);
        s_mcnt   = sat(s_mcnt + 1, 3);
        chk("sat_ferr", 32'(s_ferr), 32'(FL));
        chk("sat_total", 32'(s_total), 32'(s_mtotal));
        chk("sat_cnt", 32'(s_cnt), 32'(s_mcnt));
        @(posedge clk); #1;
        chk("sat_total_hold", 32'(s_total), 32'(s_mtotal));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_en"}, 32'(en), 32'd0);
        chk({tag, "_bit"}, 32'(enc_bit), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk_results(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; valid = 1'b0; abort = 1'b0; data = '0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        run_frame(8'hA5, 8'h00, 1'b0, -1, 1'b0);
        run_frame(8'hFF, 8'h42, 1'b0, -1, 1'b0);
        chk("inj_dec", 32'(dec_frame), 32'hBD);
        chk("inj_total", 32'(total), 32'd2);

        run_frame(8'h01, 8'h00, 1'b1, -1, 1'b0);
        run_frame(8'h80, 8'h00, 1'b0, -1, 1'b1);

        run_frame(8'h3C, 8'h11, 1'b0, 5, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_abort_done", 32'(done), 32'd0);
        end
        run_frame(8'h3C, 8'h11, 1'b0, -1, 1'b0);
        run_frame(8'h96, 8'h81, 1'b0, RL, 1'b0);

        repeat (10) begin
            int ab;
            ab = $urandom_range(0, 30);
            run_frame(8'($urandom), ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom), 1'b0,
                      (ab <= RL) ? ab : -1, 1'b0);
        end

        valid = 1'b1; data = 8'h5A;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_en", 32'(en), 32'd1);
        rst = 1'b0; #1;
        m_total = 0; m_cnt = 0; m_ferr = 0; m_dec = '0;
        chk_reset_state("midrst");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_frame(8'hC3, 8'h04, 1'b0, -1, 1'b0);

        repeat (4) run_sat();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
